mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported synchronous memory (1-cycle read latency) between the instruction-fetch port and the load/store port of the RV32 core. Grants one access per cycle, routes the read response back to its owner one cycle later, and bounds fetch starvation under back-to-back data traffic. It sits between the core and the unified memory. The load/store port carries the word address, byte enables and replicated write data already produced by the load/store alignment logic.

## Interface

Parameters:
- RR, 0: arbitration mode. 0 = data priority with starvation limit; 1 = round-robin.
- STARVE_MAX, 4: in data-priority mode, the maximum number of consecutive data grants while fetch waits. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request. Held with if_addr until if_gnt.
- if_addr  in  30  fetch word address [31:2].
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  32  fetch read data.
- d_req  in  1  load/store request. Held with d_we/d_addr/d_be/d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  30  data word address [31:2].
- d_be  in  4  byte enables.
- d_wdata  in  32  store data, lane-replicated.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid, or store acknowledge.
- d_rdata  out  32  load data. Zero on store acknowledge.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write strobe.
- mem_addr  out  30  memory word address.
- mem_be  out  4  memory byte enables. 4'hF for fetches.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after a read with mem_en=1.

## Operation

- Grant is combinational from the requests and the registered arbiter state. At most one of if_gnt/d_gnt is high. mem_en = if_gnt | d_gnt.
- The memory bus is driven from the winner's inputs. When fetch wins: mem_we=0, mem_be=4'hF, mem_wdata=0. When idle: every mem_* output is 0.
- Data-priority mode (RR=0):
  - Data wins whenever d_req is high and starve_cnt < STARVE_MAX.
  - Fetch wins when only if_req is high, or when both requests are high and starve_cnt == STARVE_MAX.
  - starve_cnt (4 bits) increments on each data grant while if_req is high.
  - starve_cnt clears on a fetch grant, or in any cycle with if_req low.
  - starve_cnt saturates at STARVE_MAX.
- Round-robin mode (RR=1):
  - A single request is always granted.
  - On a conflict, the port that did not win the last conflict is granted.
  - The last_conf register updates only on conflict cycles (0 = fetch won, 1 = data won). Its reset value is 1, so fetch wins the first conflict.
  - starve_cnt is unused and held at 0.
- Response routing:
  - Registers owner (0 = fetch, 1 = data), rd_pend and wr_ack at every grant.
  - The cycle after a fetch grant: if_rvalid=1 and if_rdata=mem_rdata.
  - The cycle after a data load grant: d_rvalid=1 and d_rdata=mem_rdata.
  - The cycle after a data store grant: d_rvalid=1 and d_rdata=0.
- rdata outputs read 0 whenever their rvalid is low.
- Back-to-back grants to any mix of ports are legal. Responses return in grant order, exactly one per grant.
- A port may drop its request before it is granted. Nothing is then issued for that port.
- Reset (async, rst_n low):
  - starve_cnt=0, last_conf=1, all response registers 0.
  - if_gnt, d_gnt, mem_en and both rvalids are forced to 0 while rst_n is low.
  - A response pending at reset assertion is discarded. No rvalid appears after reset release for a pre-reset grant.

## Timing

- Grant latency: 0 cycles (same cycle as req when the port wins).
- Response latency: exactly 1 cycle after the grant cycle, for reads and store acknowledges alike.
- Throughput: 1 access per cycle in total. In data-priority mode under continuous contention, fetch receives ≥1 grant in every STARVE_MAX+1 cycles.
- All outputs are 0 from reset assertion until the first rising edge with rst_n high and a request present.
- mem_* outputs follow the requests combinationally. The memory samples them on the rising edge.

## Test plan

- Reset check: assert rst_n=0 mid-stream with a load pending. Required: all outputs 0 immediately, and no d_rvalid after release.
- Single fetch: if_req at if_addr=30'h10, mem returns 32'h00A00093. Required: if_gnt and mem_en in cycle N; if_rvalid=1 with if_rdata=32'h00A00093 in N+1; d_rvalid stays 0.
- Store: d_req, d_we=1, d_addr=30'h40, d_be=4'b1100, d_wdata=32'hBEEFBEEF. Required: mem_we=1, mem_be=4'b1100 in cycle N; d_rvalid=1 with d_rdata=0 in N+1.
- Starvation, RR=0, STARVE_MAX=4: if_req and d_req both held high for 10 cycles. Required grant sequence D,D,D,D,F,D,D,D,D,F. starve_cnt returns to 0 after each F.
- Round-robin, RR=1: both requests held high for 4 cycles. Required grants F,D,F,D. A lone d_req in cycle 5 is granted.
- Interleaved load/fetch back-to-back: D load (30'h8), then F, then D load (30'hC). Required: d_rvalid in N+1, if_rvalid in N+2, d_rvalid in N+3, each carrying the matching mem_rdata.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported synchronous memory (1-cycle read latency)
//   between the instruction-fetch port (if_*) and the load/store port (d_*).
//   At most one access is granted per cycle. The read response, or the store
//   acknowledge, is routed back to the port that owned the access one cycle
//   after the grant.
//
//   Arbitration (parameter RR):
//     RR=0 : data has priority. After STARVE_MAX consecutive data grants
//            while fetch waits, fetch is granted once.
//     RR=1 : round-robin. On a conflict the loser of the previous conflict
//            wins. Fetch wins the first conflict after reset.
//
//   Handshake: a port raises *_req and holds its command stable until *_gnt.
//   *_gnt is combinational in the request cycle, so the transfer happens on
//   the rising edge where req and gnt are both high. A port may also drop its
//   request before it is granted. Exactly one *_rvalid pulse follows each
//   grant, on the next cycle. Responses come back in grant order.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr -> if_gnt        fetch command / accept
//   if_rvalid/if_rdata              fetch response
//   d_req/d_we/d_addr/d_be/d_wdata  load/store command -> d_gnt
//   d_rvalid/d_rdata                load data or store acknowledge (data 0)
//   mem_en/we/addr/be/wdata         memory command (all 0 when idle)
//   mem_rdata                       memory read data (cycle after a read)
module mem_port_arbiter #(
  parameter bit          RR         = 1'b0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  logic       r_last_conf;  // 0 = fetch won the last conflict, 1 = data won
  logic       r_owner;      // 0 = fetch, 1 = data; owner of the response slot
  logic       r_rd_pend;    // a read response is due this cycle
  logic       r_wr_ack;     // a store acknowledge is due this cycle

  logic       w_conflict;
  logic       w_d_win;
  logic       w_f_win;
  logic       w_if_gnt;
  logic       w_d_gnt;
  logic [3:0] w_starve_nxt;

  // Grant decision. A lone request always wins; only the conflict case
  // depends on the arbiter state. Grants are masked while reset is asserted
  // so nothing reaches the memory during reset.
  always_comb begin
    w_conflict = if_req & d_req;
    if (RR) begin
      w_d_win = d_req & (~if_req | ~r_last_conf);
    end else begin
      w_d_win = d_req & (~if_req | (r_starve_cnt < LP_STARVE_MAX));
    end
    w_f_win  = if_req & ~w_d_win;
    w_if_gnt = w_f_win & rst_n;
    w_d_gnt  = w_d_win & rst_n;
  end

  // Starvation counter: counts data grants taken while fetch is waiting,
  // saturating at STARVE_MAX. Any cycle without a fetch request, or a fetch
  // grant, ends the starvation run.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (RR || !if_req || w_if_gnt) begin
      w_starve_nxt = '0;
    end else if (w_d_gnt && (r_starve_cnt < LP_STARVE_MAX)) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_last_conf  <= 1'b1;
      r_owner      <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_wr_ack     <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      if (RR && w_conflict) begin
        r_last_conf <= w_d_gnt;
      end
      if (w_if_gnt || w_d_gnt) begin
        r_owner <= w_d_gnt;
      end
      r_rd_pend <= w_if_gnt | (w_d_gnt & ~d_we);
      r_wr_ack  <= w_d_gnt & d_we;
    end
  end

  // Memory command, driven from the winner only.
  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign mem_en    = w_if_gnt | w_d_gnt;
  assign mem_we    = w_d_gnt & d_we;
  assign mem_addr  = w_d_gnt ? d_addr  : (w_if_gnt ? if_addr : 30'd0);
  assign mem_be    = w_d_gnt ? d_be    : (w_if_gnt ? 4'hF    : 4'h0);
  assign mem_wdata = w_d_gnt ? d_wdata : 32'd0;

  // Response routing. Store acknowledges carry zero data.
  assign if_rvalid = r_rd_pend & ~r_owner & rst_n;
  assign d_rvalid  = (r_rd_pend | r_wr_ack) & r_owner & rst_n;
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  assign d_rdata   = (d_rvalid & r_rd_pend) ? mem_rdata : 32'd0;

endmodule
